// File: rtl/pipa_pulse_sampler_pkg.sv
// Shared types and constants for the PIPA pulse sampler.
// The axis enum names the three backlog lanes (X has the highest priority),
// the arbiter state enum names the request presenter states, and the
// backlog width helper gives $clog2(BACKLOG_MAX)+2 bits, which leaves room
// for the sign and for the intermediate sum of backlog, ack and sample.
package pipa_pulse_sampler_pkg;

   typedef enum logic [1:0] {
      AXIS_X = 2'd0,
      AXIS_Y = 2'd1,
      AXIS_Z = 2'd2
   } axis_e;

   typedef enum logic [0:0] {
      ARB_IDLE    = 1'b0,
      ARB_PRESENT = 1'b1
   } arb_state_e;

   localparam int BACKLOG_MAX_DEFAULT = 3;
   localparam int BACKLOG_W_DEFAULT   = $clog2(BACKLOG_MAX_DEFAULT) + 2;

   // Signed backlog width for a given saturation magnitude.
   function automatic int backlog_width(input int max_mag);
      return $clog2(max_mag) + 2;
   endfunction

endpackage

// File: rtl/pipa_axis_backlog.sv
// One PIPA axis: input synchronizers, PIPSAM sampler and the saturating
// signed backlog of pending counter pulses.
// Optional feature macro: PIPA_FAIL_DETECT_EN (plus and minus sampled
// together on this axis also raises the fail request).
module pipa_axis_backlog
   import pipa_pulse_sampler_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int BACKLOG_MAX = 3,
   parameter int BL_W        = backlog_width(BACKLOG_MAX)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_pipa_p_n,
   input  logic                   i_pipa_m_n,
   input  logic                   i_sample,
   input  logic                   i_ack,
   output logic signed [BL_W-1:0] o_backlog,
   output logic signed [BL_W-1:0] o_backlog_nxt,
   output logic                   o_fail_set
);

   localparam logic signed [BL_W:0] ZERO    = '0;
   localparam logic signed [BL_W:0] ONE     = (BL_W+1)'(32'sd1);
   localparam logic signed [BL_W:0] LIM_POS = (BL_W+1)'(BACKLOG_MAX);
   localparam logic signed [BL_W:0] LIM_NEG = -LIM_POS;

   logic [SYNC_STAGES-1:0] r_sync_p;
   logic [SYNC_STAGES-1:0] r_sync_m;
   logic signed [BL_W-1:0] r_backlog;

   logic                 w_lvl_p;
   logic                 w_lvl_m;
   logic signed [BL_W:0] w_cur;
   logic signed [BL_W:0] w_smp_d;
   logic signed [BL_W:0] w_ack_d;
   logic signed [BL_W:0] w_base;
   logic signed [BL_W:0] w_try;
   logic signed [BL_W:0] w_nxt;
   logic                 w_sat;

   // Synchronizer chains; the pins are active-low, so the chain carries the
   // inverted (active-high) level and a cleared chain means "no pulse".
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync_p <= '0;
         r_sync_m <= '0;
      end else begin
         r_sync_p <= {r_sync_p[SYNC_STAGES-2:0], ~i_pipa_p_n};
         r_sync_m <= {r_sync_m[SYNC_STAGES-2:0], ~i_pipa_m_n};
      end
   end

   assign w_lvl_p = r_sync_p[SYNC_STAGES-1];
   assign w_lvl_m = r_sync_m[SYNC_STAGES-1];

   // Next backlog: ack first moves one step toward zero, then the sample is
   // added unless the result would pass the saturation limit.
   always_comb begin
      w_cur   = {r_backlog[BL_W-1], r_backlog};
      w_smp_d = ZERO;
      w_ack_d = ZERO;
      w_sat   = 1'b0;
      if (i_sample && w_lvl_p && !w_lvl_m) begin
         w_smp_d = ONE;
      end else if (i_sample && w_lvl_m && !w_lvl_p) begin
         w_smp_d = -ONE;
      end else begin
         w_smp_d = ZERO;
      end
      if (i_ack && (w_cur > ZERO)) begin
         w_ack_d = -ONE;
      end else if (i_ack && (w_cur < ZERO)) begin
         w_ack_d = ONE;
      end else begin
         w_ack_d = ZERO;
      end
      w_base = w_cur + w_ack_d;
      w_try  = w_base + w_smp_d;
      if ((w_try > LIM_POS) || (w_try < LIM_NEG)) begin
         w_sat = 1'b1;
         w_nxt = w_base;
      end else begin
         w_sat = 1'b0;
         w_nxt = w_try;
      end
   end

   // Backlog register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_backlog <= '0;
      end else begin
         r_backlog <= w_nxt[BL_W-1:0];
      end
   end

   assign o_backlog     = r_backlog;
   assign o_backlog_nxt = w_nxt[BL_W-1:0];

`ifdef PIPA_FAIL_DETECT_EN
   logic w_both;
   assign w_both     = i_sample && w_lvl_p && w_lvl_m;
   assign o_fail_set = w_sat | w_both;
`else
   assign o_fail_set = w_sat;
`endif

endmodule

// File: rtl/pipa_pulse_sampler.sv
// PIPA pulse sampler: three axis backlogs feeding a fixed-priority (X>Y>Z)
// request presenter towards the counter sequencer.
// Optional feature macro: PIPA_FAIL_DETECT_EN enables the sticky PIPAFL
// alarm (saturation drops and plus/minus collisions); without it PIPAFL is
// tied low and CLRPF has no effect.
module pipa_pulse_sampler
   import pipa_pulse_sampler_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int BACKLOG_MAX = 3
) (
   input  logic CLOCK,
   input  logic rst,
   input  logic PIPAXp_,
   input  logic PIPAXm_,
   input  logic PIPAYp_,
   input  logic PIPAYm_,
   input  logic PIPAZp_,
   input  logic PIPAZm_,
   input  logic PIPSAM,
   input  logic CTRACK,
   input  logic CLRPF,
   output logic PIPGXp,
   output logic PIPGXm,
   output logic PIPGYp,
   output logic PIPGYm,
   output logic PIPGZp,
   output logic PIPGZm,
   output logic PIPSAM_,
   output logic PIPAFL
);

   localparam int         BL_W       = backlog_width(BACKLOG_MAX);
   localparam logic [0:0] ST_IDLE    = ARB_IDLE;
   localparam logic [0:0] ST_PRESENT = ARB_PRESENT;

   logic r_rst_meta;
   logic r_rst_sync;
   logic w_rst_n;

   logic [2:0]             w_p_n;
   logic [2:0]             w_m_n;
   logic [2:0]             w_ack;
   logic [2:0]             w_fail;
   logic signed [BL_W-1:0] w_bl     [3];
   logic signed [BL_W-1:0] w_bl_nxt [3];

   logic [0:0] r_state;
   logic       r_gap;
   logic [5:0] r_pipg;
   axis_e      r_sel;
   logic       r_pipsam_n;

   logic [5:0] w_pick;
   axis_e      w_pick_axis;
   logic       w_any_nz;
   logic       w_all_nxt_zero;
   logic       w_presenting;

   // Reset synchronizer: assertion is immediate, release waits two edges.
   always_ff @(posedge CLOCK or negedge rst) begin
      if (!rst) begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= r_rst_meta;
      end
   end

   assign w_rst_n = r_rst_sync;

   assign w_p_n = {PIPAZp_, PIPAYp_, PIPAXp_};
   assign w_m_n = {PIPAZm_, PIPAYm_, PIPAXm_};

   for (genvar gi = 0; gi < 3; gi++) begin : g_axis
      pipa_axis_backlog #(
         .SYNC_STAGES (SYNC_STAGES),
         .BACKLOG_MAX (BACKLOG_MAX),
         .BL_W        (BL_W)
      ) u_axis (
         .i_clk         (CLOCK),
         .i_rst_n       (w_rst_n),
         .i_pipa_p_n    (w_p_n[gi]),
         .i_pipa_m_n    (w_m_n[gi]),
         .i_sample      (PIPSAM),
         .i_ack         (w_ack[gi]),
         .o_backlog     (w_bl[gi]),
         .o_backlog_nxt (w_bl_nxt[gi]),
         .o_fail_set    (w_fail[gi])
      );
   end

   // Highest-priority nonzero backlog and its direction (sign bit = minus).
   always_comb begin
      w_pick      = 6'b000000;
      w_pick_axis = AXIS_X;
      if (w_bl[0] != '0) begin
         w_pick_axis = AXIS_X;
         w_pick      = w_bl[0][BL_W-1] ? 6'b000010 : 6'b000001;
      end else if (w_bl[1] != '0) begin
         w_pick_axis = AXIS_Y;
         w_pick      = w_bl[1][BL_W-1] ? 6'b001000 : 6'b000100;
      end else if (w_bl[2] != '0) begin
         w_pick_axis = AXIS_Z;
         w_pick      = w_bl[2][BL_W-1] ? 6'b100000 : 6'b010000;
      end else begin
         w_pick_axis = AXIS_X;
         w_pick      = 6'b000000;
      end
   end

   assign w_any_nz       = |w_pick;
   assign w_presenting   = (r_state == ST_PRESENT) && !r_gap;
   assign w_all_nxt_zero = (w_bl_nxt[0] == '0) && (w_bl_nxt[1] == '0) &&
                           (w_bl_nxt[2] == '0);

   // Route CTRACK to the axis whose request is on the lines; ignored otherwise.
   always_comb begin
      w_ack = 3'b000;
      if (w_presenting && CTRACK) begin
         case (r_sel)
            AXIS_X:  w_ack = 3'b001;
            AXIS_Y:  w_ack = 3'b010;
            AXIS_Z:  w_ack = 3'b100;
            default: w_ack = 3'b000;
         endcase
      end else begin
         w_ack = 3'b000;
      end
   end

   // Request presenter: latch a request, hold it until CTRACK, then leave the
   // lines low for one cycle (r_gap) before looking at the backlogs again.
   always_ff @(posedge CLOCK or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= ST_IDLE;
         r_gap   <= 1'b0;
         r_pipg  <= 6'b000000;
         r_sel   <= AXIS_X;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_gap <= 1'b0;
               if (w_any_nz) begin
                  r_state <= ST_PRESENT;
                  r_pipg  <= w_pick;
                  r_sel   <= w_pick_axis;
               end else begin
                  r_pipg  <= 6'b000000;
               end
            end
            ST_PRESENT: begin
               if (r_gap) begin
                  r_gap <= 1'b0;
                  if (w_any_nz) begin
                     r_pipg <= w_pick;
                     r_sel  <= w_pick_axis;
                  end else begin
                     r_state <= ST_IDLE;
                     r_pipg  <= 6'b000000;
                  end
               end else if (CTRACK) begin
                  r_pipg <= 6'b000000;
                  if (w_all_nxt_zero) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_gap   <= 1'b1;
                  end
               end else begin
                  r_pipg <= r_pipg;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gap   <= 1'b0;
               r_pipg  <= 6'b000000;
            end
         endcase
      end
   end

   // Registered inverse of the sample strobe.
   always_ff @(posedge CLOCK or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_pipsam_n <= 1'b1;
      end else begin
         r_pipsam_n <= ~PIPSAM;
      end
   end

`ifdef PIPA_FAIL_DETECT_EN
   logic r_pipafl;

   // Sticky alarm; a new fail condition wins over a simultaneous clear.
   always_ff @(posedge CLOCK or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_pipafl <= 1'b0;
      end else if (|w_fail) begin
         r_pipafl <= 1'b1;
      end else if (CLRPF) begin
         r_pipafl <= 1'b0;
      end else begin
         r_pipafl <= r_pipafl;
      end
   end

   assign PIPAFL = r_pipafl;
`else
   logic w_unused_fail;
   assign w_unused_fail = CLRPF ^ (|w_fail);
   assign PIPAFL        = 1'b0;
`endif

   assign PIPGXp  = r_pipg[0];
   assign PIPGXm  = r_pipg[1];
   assign PIPGYp  = r_pipg[2];
   assign PIPGYm  = r_pipg[3];
   assign PIPGZp  = r_pipg[4];
   assign PIPGZm  = r_pipg[5];
   assign PIPSAM_ = r_pipsam_n;

endmodule

// File: doc/pipa_pulse_sampler.md
PIPA_PULSE_SAMPLER -- requirements
Module: pipa_pulse_sampler

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops per PIPA input, legal range 2..3.
REQ-002 Parameter BACKLOG_MAX, default 3: largest magnitude of each per-axis signed backlog.
REQ-003 The block SHALL use exactly one clock and one reset: CLOCK is the sole clock, and rst is an asynchronous, active-low reset.
REQ-004 CLOCK  in  1  system clock, rising-edge active.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 PIPAXp_, PIPAXm_, PIPAYp_, PIPAYm_, PIPAZp_, PIPAZm_  in  1 each  asynchronous active-low PIPA pulses, plus/minus per axis.
REQ-007 PIPSAM  in  1  sample strobe, one CLOCK cycle wide.
REQ-008 CTRACK  in  1  counter sequencer accepts the currently presented request.
REQ-009 PIPGXp, PIPGXm, PIPGYp, PIPGYm, PIPGZp, PIPGZm  out  1 each  counter increment/decrement requests; at most one is high per cycle.
REQ-010 PIPSAM_  out  1  registered inverse of PIPSAM.
REQ-011 PIPAFL  out  1  sticky PIPA fail alarm.
REQ-012 CLRPF  in  1  synchronous clear of PIPAFL.

Function
REQ-013 Each PIPA input SHALL pass through a SYNC_STAGES flop synchronizer, and its inverted output is the per-axis sampled level.
REQ-014 On a cycle with PIPSAM=1, each axis SHALL sample its synchronized plus and minus levels once.
REQ-015 Sample plus only: the backlog increments by 1. Sample minus only: the backlog decrements by 1. Both or neither: the backlog is unchanged.
REQ-016 Backlog SHALL saturate at +/-BACKLOG_MAX; a sample that would exceed the limit is dropped and sets PIPAFL.
REQ-017 Arbiter states: IDLE and PRESENT.
- IDLE to PRESENT: the cycle after any backlog becomes nonzero.
- PRESENT to IDLE: on CTRACK when all backlogs are zero after the update.
REQ-018 Arbiter priority SHALL be X > Y > Z; the presented request is fixed, and does not change, until CTRACK.
REQ-019 Request direction SHALL equal the sign of the axis backlog; the request line is registered and held stable until acknowledged.
REQ-020 On CTRACK the presented axis backlog SHALL move 1 toward zero, and the request lines deassert for exactly one cycle before the next request.
REQ-021 If CTRACK and a PIPSAM update hit the same axis in the same cycle, both SHALL apply, giving a net backlog change in -2..+2 after saturation.
REQ-022 CTRACK while in IDLE SHALL be ignored.
REQ-023 Latency: an input edge to a request high SHALL take at most SYNC_STAGES + 2 cycles after the PIPSAM that samples it.
REQ-024 PIPSAM_ SHALL equal the inverse of PIPSAM delayed by one cycle.
REQ-025 CLRPF SHALL clear PIPAFL; if a set condition occurs in the same cycle, the set wins.

Reset
REQ-026 On rst=0, the block SHALL asynchronously clear:
- synchronizers and backlogs to 0;
- arbiter to IDLE;
- all PIPG* outputs to 0;
- PIPAFL to 0;
- PIPSAM_ to 1.
REQ-027 Reset asserted mid-request SHALL drop the pending request without waiting for acknowledge.
REQ-028 Reset deassertion SHALL be synchronized to CLOCK, and the first sample is taken at the first PIPSAM after release.

Configuration
REQ-029 Macro PIPA_FAIL_DETECT_EN compiled in: a sample with both plus and minus active on one axis SHALL also set PIPAFL, in addition to saturation.
REQ-030 Macro PIPA_FAIL_DETECT_EN compiled out: PIPAFL SHALL be tied to 0, CLRPF is ignored, saturation drops samples silently, and simultaneous plus/minus samples cancel.

Structure
REQ-031 A shared package SHALL hold:
- the axis enum (X, Y, Z);
- the arbiter state enum;
- the backlog width constant $clog2(BACKLOG_MAX)+2.
REQ-032 One sub-module, pipa_axis_backlog, SHALL hold the synchronizer, sampler and saturating backlog for one axis, instantiated three times; the arbiter stays in the top level.

Verification
REQ-033 Pulse PIPAXp_=0 for 4 cycles, then PIPSAM -> PIPGXp=1 within 4 cycles and held; CTRACK -> PIPGXp=0, arbiter IDLE.
REQ-034 X+ and Z- sampled on the same PIPSAM -> PIPGXp is served first; after CTRACK, one low cycle, then PIPGZm.
REQ-035 Four PIPSAM with PIPAYp_=0 and no CTRACK -> backlog Y = +3, the fourth sample is dropped, PIPAFL=1; CLRPF -> PIPAFL=0.
REQ-036 PIPAXp_ and PIPAXm_ both low at PIPSAM -> no request; PIPAFL=1 only with PIPA_FAIL_DETECT_EN defined.
REQ-037 rst pulsed low while PIPGYm=1 with backlog Y = -2 -> PIPGYm=0 immediately, backlog Y = 0, PIPSAM_=1.
REQ-038 CTRACK on X coincident with a new X+ PIPSAM at backlog +1 -> backlog stays +1 and PIPGXp reasserts after one low cycle.
